// File: rtl/lynx_tape_pkg.sv
// Shared types for the Lynx48 tape loader / main-RAM arbitration slice.
package lynx_tape_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    JUMP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/tape_wr_fifo.sv
// Small synchronous FIFO for loader writes; a push into a full FIFO only
// succeeds when the head is popped on the same clock.
module tape_wr_fifo
  import lynx_tape_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W+DATA_W-1:0]   push_data,
  input  logic                       pop,
  output logic [ADDR_W+DATA_W-1:0]   head,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW:0]              count;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tape_ram_arbiter.sv
// Shares the main-RAM write port between the Z80 and the cassette loader and
// hands the tape exec address to the CPU-side jump logic.
module tape_ram_arbiter
  import lynx_tape_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_complete,
  input  logic        cpu_mreq,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        jump_req,
  output logic [15:0] jump_addr,
  input  logic        jump_ack,
  output logic        busy,
  output logic        overflow
);

  localparam logic [9:0] TIMEOUT_MAX = 10'(ACK_TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic        dl_d;
  logic        wr_d;
  logic        complete_d;
  logic [15:0] last_addr;
  logic        complete_seen;
  logic [9:0]  timer;
  logic        dl_rise;
  logic        dl_fall;
  logic        complete_rise;
  logic        push_req;
  logic        fifo_pop;
  logic        cpu_sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        enter_load;
  logic [ADDR_W+DATA_W-1:0] head_bits;
  fifo_entry_t head;

  assign dl_rise       = ioctl_download && !dl_d;
  assign dl_fall       = !ioctl_download && dl_d;
  assign complete_rise = tape_complete && !complete_d;
  assign push_req      = tape_wr && (!wr_d || (tape_addr != last_addr));
  assign head          = fifo_entry_t'(head_bits);
  assign enter_load    = (state_next == LOAD) && (state != LOAD);

  assign cpu_wait = (state != IDLE);
  assign busy     = (state != IDLE);
  assign jump_req = (state == JUMP);

  tape_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_data({tape_addr, tape_dout}),
    .pop      (fifo_pop),
    .head     (head_bits),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Next state plus port ownership; the loader only wins the port in IDLE/JUMP when the CPU is quiet.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    cpu_sel    = 1'b0;
    case (state)
      IDLE:  if (dl_rise) state_next = LOAD;
      LOAD:  if (dl_fall || complete_rise) state_next = DRAIN;
      DRAIN: begin
        if (dl_rise) state_next = LOAD;
        else if (fifo_empty) state_next = complete_seen ? JUMP : IDLE;
      end
      JUMP: begin
        if (dl_rise) state_next = LOAD;
        else if (jump_ack || (timer == TIMEOUT_MAX - 10'd1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if ((state == LOAD) || (state == DRAIN)) begin
      fifo_pop = !fifo_empty;
    end else begin
      cpu_sel  = cpu_mreq;
      fifo_pop = !cpu_mreq && !fifo_empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dl_d          <= 1'b0;
      wr_d          <= 1'b0;
      complete_d    <= 1'b0;
      last_addr     <= '0;
      complete_seen <= 1'b0;
      jump_addr     <= '0;
      overflow      <= 1'b0;
      timer         <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_din       <= '0;
    end else begin
      state      <= state_next;
      dl_d       <= ioctl_download;
      wr_d       <= tape_wr;
      complete_d <= tape_complete;
      if (push_req) last_addr <= tape_addr;

      if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
      else if (dl_rise) overflow <= 1'b0;

      if (enter_load) begin
        complete_seen <= 1'b0;
      end else if ((state == LOAD) && complete_rise) begin
        complete_seen <= 1'b1;
        jump_addr     <= tape_addr;
      end

      // Cleared on entry, then counts up and parks at the limit.
      if ((state != JUMP) && (state_next == JUMP)) timer <= '0;
      else if ((state == JUMP) && (timer != TIMEOUT_MAX)) timer <= timer + 10'd1;

      ram_we <= cpu_sel || fifo_pop;
      if (cpu_sel) begin
        ram_addr <= cpu_addr;
        ram_din  <= cpu_dout;
      end else if (fifo_pop) begin
        ram_addr <= head.addr;
        ram_din  <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Directed bench for tape_ram_arbiter: loader writes, dedup, overflow,
// jump handshake, ack timeout and reset mid-load.
module tb_tape_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_complete;
  logic        cpu_mreq;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        jump_req;
  logic [15:0] jump_addr;
  logic        jump_ack;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tape_ram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .tape_wr       (tape_wr),
    .tape_addr     (tape_addr),
    .tape_dout     (tape_dout),
    .tape_complete (tape_complete),
    .cpu_mreq      (cpu_mreq),
    .cpu_addr      (cpu_addr),
    .cpu_dout      (cpu_dout),
    .cpu_wait      (cpu_wait),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .jump_req      (jump_req),
    .jump_addr     (jump_addr),
    .jump_ack      (jump_ack),
    .busy          (busy),
    .overflow      (overflow)
  );

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [15:0] wa;
    logic [7:0]  wd;

    reset = 1'b1; ioctl_download = 1'b0; tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
    tape_complete = 1'b0; cpu_mreq = 1'b0; cpu_addr = '0; cpu_dout = '0; jump_ack = 1'b0;
    applyStimulus(2);
    checkOutput("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_jump_req", 32'(jump_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_jump_addr", 32'(jump_addr), 32'd0);
    reset = 1'b0;
    applyStimulus(1);

    $display("[TB] three loader writes during download");
    ioctl_download = 1'b1;
    applyStimulus(1);
    checkOutput("load_cpu_wait", 32'(cpu_wait), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    tape_wr = 1'b1; tape_addr = 16'h694D; tape_dout = 8'h11;
    applyStimulus(1);
    checkOutput("push_latency_we", 32'(ram_we), 32'd0);
    tape_addr = 16'h694E; tape_dout = 8'h22;
    applyStimulus(1);
    checkOutput("w1_we", 32'(ram_we), 32'd1);
    checkOutput("w1_addr", 32'(ram_addr), 32'h694D);
    checkOutput("w1_din", 32'(ram_din), 32'h11);
    tape_addr = 16'h694F; tape_dout = 8'h33;
    applyStimulus(1);
    checkOutput("w2_we", 32'(ram_we), 32'd1);
    checkOutput("w2_addr", 32'(ram_addr), 32'h694E);
    checkOutput("w2_din", 32'(ram_din), 32'h22);
    tape_wr = 1'b0;
    applyStimulus(1);
    checkOutput("w3_we", 32'(ram_we), 32'd1);
    checkOutput("w3_addr", 32'(ram_addr), 32'h694F);
    checkOutput("w3_din", 32'(ram_din), 32'h33);
    checkOutput("w3_cpu_wait", 32'(cpu_wait), 32'd1);
    applyStimulus(1);
    checkOutput("drained_we", 32'(ram_we), 32'd0);

    $display("[TB] tape_wr held high at one address");
    tape_wr = 1'b1; tape_addr = 16'h694D; tape_dout = 8'hAA;
    n = 0; wa = '0; wd = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) tape_wr = 1'b0;
      applyStimulus(1);
      if (ram_we === 1'b1) begin
        n++; wa = ram_addr; wd = ram_din;
      end
    end
    checkOutput("held_write_count", 32'(n), 32'd1);
    checkOutput("held_write_addr", 32'(wa), 32'h694D);
    checkOutput("held_write_din", 32'(wd), 32'hAA);

    $display("[TB] tape_complete and jump handshake");
    tape_addr = 16'h6950; tape_complete = 1'b1;
    applyStimulus(1);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_jump_req", 32'(jump_req), 32'd0);
    checkOutput("latched_jump_addr", 32'(jump_addr), 32'h6950);
    applyStimulus(1);
    checkOutput("jump_req_set", 32'(jump_req), 32'd1);
    checkOutput("jump_cpu_wait", 32'(cpu_wait), 32'd1);
    applyStimulus(2);
    checkOutput("jump_req_hold", 32'(jump_req), 32'd1);
    jump_ack = 1'b1;
    applyStimulus(1);
    jump_ack = 1'b0;
    checkOutput("ack_jump_req", 32'(jump_req), 32'd0);
    checkOutput("ack_cpu_wait", 32'(cpu_wait), 32'd0);
    checkOutput("ack_busy", 32'(busy), 32'd0);
    tape_complete = 1'b0; ioctl_download = 1'b0;
    applyStimulus(1);

    $display("[TB] CPU write in IDLE");
    cpu_mreq = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h5A;
    applyStimulus(1);
    checkOutput("cpu_we", 32'(ram_we), 32'd1);
    checkOutput("cpu_addr", 32'(ram_addr), 32'h1234);
    checkOutput("cpu_din", 32'(ram_din), 32'h5A);

    $display("[TB] five pushes while CPU holds the port");
    for (int i = 0; i < 5; i++) begin
      tape_wr = 1'b1; tape_addr = 16'h7000 + 16'(i); tape_dout = 8'h40 + 8'(i);
      applyStimulus(1);
      if (i == 3) checkOutput("ovf_before_full", 32'(overflow), 32'd0);
    end
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    tape_wr = 1'b0; cpu_mreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("ovf_pop_we", 32'(ram_we), 32'd1);
      checkOutput("ovf_pop_addr", 32'(ram_addr), 32'h7000 + 32'(i));
      checkOutput("ovf_pop_din", 32'(ram_din), 32'h40 + 32'(i));
    end
    applyStimulus(1);
    checkOutput("ovf_fifth_dropped", 32'(ram_we), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    ioctl_download = 1'b1;
    applyStimulus(1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    checkOutput("reload_cpu_wait", 32'(cpu_wait), 32'd1);

    $display("[TB] jump without ack");
    tape_addr = 16'h6000; tape_complete = 1'b1;
    applyStimulus(2);
    checkOutput("to_jump_addr", 32'(jump_addr), 32'h6000);
    checkOutput("to_jump_req", 32'(jump_req), 32'd1);
    n = 0;
    while ((jump_req === 1'b1) && (n < 1100)) begin
      n++;
      applyStimulus(1);
    end
    checkOutput("timeout_req_cycles", 32'(n), 32'd1023);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_cpu_wait", 32'(cpu_wait), 32'd0);

    $display("[TB] reset during LOAD with queued entries");
    tape_complete = 1'b0; ioctl_download = 1'b0;
    applyStimulus(1);
    cpu_mreq = 1'b1; cpu_addr = 16'h1111; cpu_dout = 8'h01;
    tape_wr = 1'b1; tape_addr = 16'h8000; tape_dout = 8'hC0;
    applyStimulus(1);
    tape_addr = 16'h8001; tape_dout = 8'hC1;
    applyStimulus(1);
    tape_wr = 1'b0; ioctl_download = 1'b1;
    applyStimulus(1);
    checkOutput("pre_rst_cpu_wait", 32'(cpu_wait), 32'd1);
    checkOutput("pre_rst_ram_we", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("midrst_cpu_wait", 32'(cpu_wait), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_jump_req", 32'(jump_req), 32'd0);
    checkOutput("midrst_jump_addr", 32'(jump_addr), 32'd0);
    checkOutput("midrst_ram_addr", 32'(ram_addr), 32'd0);
    applyStimulus(1);
    cpu_mreq = 1'b0; ioctl_download = 1'b0;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      if (ram_we !== 1'b0) n++;
    end
    checkOutput("post_rst_no_writes", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
